// File: rtl/sprite_datapath.sv
// Sprite raster-scan datapath: walks a SPRITE_W x SPRITE_H block at the sprite
// position, owns position/velocity state and reports scan completion and edge hits.
module sprite_datapath #(
  parameter int         SPRITE_W    = 16,
  parameter int         SPRITE_H    = 16,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         X_INIT      = 72,
  parameter int         Y_INIT      = 52,
  parameter int         STEP        = 1,
  parameter logic [2:0] DRAW_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       datapath_en,
  input  logic [1:0] op,
  input  logic       load_coord,
  input  logic       move_en,
  input  logic [1:0] steer,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       done,
  output logic       touch_edge
);

  localparam int CXW = $clog2(SPRITE_W);
  localparam int CYW = $clog2(SPRITE_H);
  localparam logic signed [9:0] X_LIM  = 10'(SCREEN_W - SPRITE_W);
  localparam logic signed [9:0] Y_LIM  = 10'(SCREEN_H - SPRITE_H);
  localparam logic signed [9:0] STEP_S = 10'(STEP);

  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [7:0]     pos_x;
  logic [6:0]     pos_y;
  logic           dx_neg;
  logic           dy_neg;
  logic [1:0]     pend;

  logic                cx_last, cy_last, steer_valid, dx_eff;
  logic signed [9:0]   x_raw, y_raw;
  logic                x_hit, y_hit;
  logic [7:0]          x_new;
  logic [6:0]          y_new;

  // Unclamped one-step move, kept signed and wide so it can neither wrap nor underflow.
  function automatic logic signed [9:0] raw_step(input logic [8:0] pos, input logic neg);
    logic signed [9:0] p;
    p = $signed({1'b0, pos});
    raw_step = neg ? (p - STEP_S) : (p + STEP_S);
  endfunction

  function automatic logic signed [9:0] sat_pos(input logic signed [9:0] v,
                                                input logic signed [9:0] lim);
    if (v > lim)
      sat_pos = lim;
    else if (v[9])
      sat_pos = '0;
    else
      sat_pos = v;
  endfunction

  assign cx_last     = (cx == CXW'(SPRITE_W - 1));
  assign cy_last     = (cy == CYW'(SPRITE_H - 1));
  assign done        = datapath_en & cx_last & cy_last;
  assign x_out       = pos_x + 8'(cx);
  assign y_out       = pos_y + 7'(cy);
  assign colour      = (op == 2'b00) ? DRAW_COLOUR : BG_COLOUR;
  assign steer_valid = move_en & ((steer == 2'b01) | (steer == 2'b10));

  // A pending steer overrides the horizontal direction for the step it is consumed by.
  always_comb begin
    dx_eff = dx_neg;
    if (pend == 2'b01)
      dx_eff = 1'b1;
    else if (pend == 2'b10)
      dx_eff = 1'b0;
    x_raw = raw_step({1'b0, pos_x}, dx_eff);
    y_raw = raw_step({2'b00, pos_y}, dy_neg);
    x_hit = (x_raw > X_LIM) | x_raw[9];
    y_hit = (y_raw > Y_LIM) | y_raw[9];
    x_new = 8'(sat_pos(x_raw, X_LIM));
    y_new = 7'(sat_pos(y_raw, Y_LIM));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx         <= '0;
      cy         <= '0;
      pos_x      <= 8'(X_INIT);
      pos_y      <= 7'(Y_INIT);
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      pend       <= 2'b00;
      touch_edge <= 1'b0;
    end else begin
      if (!datapath_en) begin
        cx <= '0;
        cy <= '0;
      end else begin
        cx <= cx + 1'b1;
        if (cx_last)
          cy <= cy + 1'b1;
      end

      // A fresh sample taken alongside a step survives the clear and applies to the next step.
      if (steer_valid)
        pend <= steer;
      else if (load_coord)
        pend <= 2'b00;

      if (load_coord) begin
        pos_x      <= x_new;
        dx_neg     <= dx_eff ^ x_hit;
        pos_y      <= y_new;
        dy_neg     <= dy_neg ^ y_hit;
        touch_edge <= y_hit & ~dy_neg;
      end
    end
  end

endmodule

// File: tb/tb_sprite_datapath.sv
// Scoreboard-driven bench for sprite_datapath: expected pixels/state are queued
// as stimulus is applied and compared once the DUT presents them.
module tb_sprite_datapath;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       datapath_en = 1'b0;
  logic [1:0] op = 2'b00;
  logic       load_coord = 1'b0;
  logic       move_en = 1'b0;
  logic [1:0] steer = 2'b00;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       done;
  logic       touch_edge;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       d;
    logic       t;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_o;
  int   n_cmp = 0;
  int   n_bad = 0;

  sprite_datapath dut (
    .clk(clk), .reset_n(reset_n), .datapath_en(datapath_en), .op(op),
    .load_coord(load_coord), .move_en(move_en), .steer(steer),
    .x_out(x_out), .y_out(y_out), .colour(colour), .done(done), .touch_edge(touch_edge)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    datapath_en = 1'b0;
    load_coord = 1'b0;
    move_en = 1'b0;
    steer = 2'b00;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    op = 2'b00;
    sb.push_back(obs_t'{8'd72, 7'd52, 3'd7, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL reset_idle: got x=%0d y=%0d c=%0d d=%b t=%b, need x=%0d y=%0d c=%0d d=%b t=%b",
               got.x, got.y, got.c, got.d, got.t, exp_o.x, exp_o.y, exp_o.c, exp_o.d, exp_o.t);
    end
    op = 2'b10;
    sb.push_back(obs_t'{8'd72, 7'd52, 3'd0, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL reset_op1x: got x=%0d y=%0d c=%0d d=%b t=%b, need x=%0d y=%0d c=%0d d=%b t=%b",
               got.x, got.y, got.c, got.d, got.t, exp_o.x, exp_o.y, exp_o.c, exp_o.d, exp_o.t);
    end
    op = 2'b00;
    reset_n = 1'b0;
    sb.push_back(obs_t'{8'd72, 7'd52, 3'd7, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL reset_held: got x=%0d y=%0d c=%0d d=%b t=%b, need x=%0d y=%0d c=%0d d=%b t=%b",
               got.x, got.y, got.c, got.d, got.t, exp_o.x, exp_o.y, exp_o.c, exp_o.d, exp_o.t);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_draw_scan();
    op = 2'b00;
    for (int k = 0; k <= 256; k++) begin
      int kk;
      kk = k % 256;
      datapath_en = 1'b1;
      sb.push_back(obs_t'{8'(72 + kk % 16), 7'(52 + kk / 16), 3'd7, (k == 255), 1'b0});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL draw_scan[%0d]: got x=%0d y=%0d c=%0d d=%b t=%b, need x=%0d y=%0d c=%0d d=%b t=%b",
                 k, got.x, got.y, got.c, got.d, got.t, exp_o.x, exp_o.y, exp_o.c, exp_o.d, exp_o.t);
      end
      tick();
    end
    datapath_en = 1'b0;
    tick();
  endtask

  task automatic test_erase_abort();
    op = 2'b01;
    for (int k = 0; k < 100; k++) begin
      datapath_en = 1'b1;
      sb.push_back(obs_t'{8'(72 + k % 16), 7'(52 + k / 16), 3'd0, 1'b0, 1'b0});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL erase_scan[%0d]: got x=%0d y=%0d c=%0d d=%b, need x=%0d y=%0d c=%0d d=%b",
                 k, got.x, got.y, got.c, got.d, exp_o.x, exp_o.y, exp_o.c, exp_o.d);
      end
      tick();
    end
    // Enable dropped: pixel 100 still on the outputs, but no done and counters clear at the edge.
    datapath_en = 1'b0;
    sb.push_back(obs_t'{8'd76, 7'd58, 3'd0, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL erase_drop: got x=%0d y=%0d c=%0d d=%b, need x=%0d y=%0d c=%0d d=%b",
               got.x, got.y, got.c, got.d, exp_o.x, exp_o.y, exp_o.c, exp_o.d);
    end
    tick();
    for (int k = 0; k < 256; k++) begin
      datapath_en = 1'b1;
      sb.push_back(obs_t'{8'(72 + k % 16), 7'(52 + k / 16), 3'd0, (k == 255), 1'b0});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL erase_restart[%0d]: got x=%0d y=%0d c=%0d d=%b, need x=%0d y=%0d c=%0d d=%b",
                 k, got.x, got.y, got.c, got.d, exp_o.x, exp_o.y, exp_o.c, exp_o.d);
      end
      tick();
    end
    datapath_en = 1'b0;
    op = 2'b00;
    tick();
  endtask

  task automatic test_load_during_scan();
    do_reset();
    op = 2'b00;
    for (int k = 0; k < 8; k++) begin
      datapath_en = 1'b1;
      load_coord = (k == 5);
      if (k <= 5)
        sb.push_back(obs_t'{8'(72 + k), 7'd52, 3'd7, 1'b0, 1'b0});
      else
        sb.push_back(obs_t'{8'(73 + k), 7'd53, 3'd7, 1'b0, 1'b0});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL load_mid_scan[%0d]: got x=%0d y=%0d, need x=%0d y=%0d",
                 k, got.x, got.y, exp_o.x, exp_o.y);
      end
      tick();
    end
    load_coord = 1'b0;
    datapath_en = 1'b0;
    tick();
  endtask

  task automatic test_bounce();
    do_reset();
    op = 2'b00;
    for (int i = 1; i <= 54; i++) begin
      int ey;
      load_coord = 1'b1;
      tick();
      load_coord = 1'b0;
      ey = (i <= 52) ? 52 + i : ((i == 53) ? 104 : 103);
      sb.push_back(obs_t'{8'(72 + i), 7'(ey), 3'd7, 1'b0, (i == 53)});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL bounce_step[%0d]: got x=%0d y=%0d t=%b, need x=%0d y=%0d t=%b",
                 i, got.x, got.y, got.t, exp_o.x, exp_o.y, exp_o.t);
      end
    end
  endtask

  // Continues from the bounce state: (126,103), moving right and up.
  task automatic test_steer();
    int ex[5] = '{125, 124, 123, 124, 123};
    int ey[5] = '{102, 101, 100, 99, 98};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: begin move_en = 1'b1; steer = 2'b01; tick(); move_en = 1'b0; steer = 2'b00; end
        2: begin move_en = 1'b1; steer = 2'b10; end
        4: begin
          move_en = 1'b1; steer = 2'b01; tick();
          steer = 2'b11; tick();
          move_en = 1'b0; steer = 2'b00;
        end
        default: ;
      endcase
      load_coord = 1'b1;
      tick();
      load_coord = 1'b0;
      move_en = 1'b0;
      steer = 2'b00;
      sb.push_back(obs_t'{8'(ex[i]), 7'(ey[i]), 3'd7, 1'b0, 1'b0});
      #1;
      got = {x_out, y_out, colour, done, touch_edge};
      exp_o = sb.pop_front(); n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL steer_step[%0d]: got x=%0d y=%0d t=%b, need x=%0d y=%0d t=%b",
                 i, got.x, got.y, got.t, exp_o.x, exp_o.y, exp_o.t);
      end
    end
  endtask

  task automatic test_right_clamp();
    int want[3] = '{144, 144, 143};
    do_reset();
    for (int i = 0; i < 71; i++) begin
      load_coord = 1'b1;
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      load_coord = 1'b1;
      tick();
      load_coord = 1'b0;
      #1;
      n_cmp++;
      if (x_out !== 8'(want[j])) begin
        n_bad++;
        $display("FAIL right_clamp[%0d]: got x=%0d, need x=%0d", j, x_out, want[j]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 53; i++) begin
      load_coord = 1'b1;
      tick();
    end
    load_coord = 1'b0;
    #1;
    n_cmp++;
    if (touch_edge !== 1'b1) begin
      n_bad++;
      $display("FAIL touch_before_reset: got %b, need 1", touch_edge);
    end
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      datapath_en = 1'b1;
      tick();
    end
    reset_n = 1'b0;
    sb.push_back(obs_t'{8'd72, 7'd52, 3'd7, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL async_reset: got x=%0d y=%0d c=%0d d=%b t=%b, need x=%0d y=%0d c=%0d d=%b t=%b",
               got.x, got.y, got.c, got.d, got.t, exp_o.x, exp_o.y, exp_o.c, exp_o.d, exp_o.t);
    end
    tick();
    reset_n = 1'b1;
    sb.push_back(obs_t'{8'd72, 7'd52, 3'd7, 1'b0, 1'b0});
    #1;
    got = {x_out, y_out, colour, done, touch_edge};
    exp_o = sb.pop_front(); n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL post_reset_pixel0: got x=%0d y=%0d d=%b, need x=%0d y=%0d d=%b",
               got.x, got.y, got.d, exp_o.x, exp_o.y, exp_o.d);
    end
    tick();
    datapath_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_draw_scan();
    test_erase_abort();
    test_load_during_scan();
    test_bounce();
    test_steer();
    test_right_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
